// File: rtl/mips_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : mips_run_ctrl_if
// Brief   : Control, status and core-snoop signals of the MIPS run controller.
// Revision: 1.0
// ============================================================================
interface mips_run_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int CYCLE_W = 32
);
    logic               start_i;
    logic               abort_i;
    logic [ADDR_W-1:0]  pc_i;
    logic               mem_we_i;
    logic [ADDR_W-1:0]  mem_addr_i;
    logic [DATA_W-1:0]  mem_wdata_i;
    logic               core_rst_n_o;
    logic               core_en_o;
    logic               busy_o;
    logic               done_o;
    logic               pass_o;
    logic [1:0]         fail_code_o;
    logic [CYCLE_W-1:0] cycles_o;
    logic [DATA_W-1:0]  result_o;

    modport master (
        output start_i, abort_i, pc_i, mem_we_i, mem_addr_i, mem_wdata_i,
        input  core_rst_n_o, core_en_o, busy_o, done_o, pass_o, fail_code_o,
               cycles_o, result_o
    );

    modport slave (
        input  start_i, abort_i, pc_i, mem_we_i, mem_addr_i, mem_wdata_i,
        output core_rst_n_o, core_en_o, busy_o, done_o, pass_o, fail_code_o,
               cycles_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mips_run_ctrl
// Brief   : Sequences core reset, gates execution, counts run cycles and
//           latches a pass/fail verdict on tohost, halt, abort or timeout.
// Revision: 1.0
// ============================================================================
module mips_run_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                CYCLE_W     = 32,
    parameter int                RST_HOLD    = 4,
    parameter int                MAX_CYCLES  = 1000,
    parameter logic [ADDR_W-1:0] HALT_PC     = 'h0000_00FC,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h0000_FFF0
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_run_ctrl_if.slave    bus
);
    localparam int                 HOLD_W       = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  c_HOLD_LOAD  = HOLD_W'(RST_HOLD - 1);
    localparam logic [CYCLE_W-1:0] c_TIMEOUT_AT = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [1:0]         c_PASS       = 2'd0;
    localparam logic [1:0]         c_TEST_FAIL  = 2'd1;
    localparam logic [1:0]         c_TIMEOUT    = 2'd2;
    localparam logic [1:0]         c_ABORT      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               core_en_q, core_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d;
    logic [DATA_W-1:0]  result_q, result_d;

    logic               w_tohost;
    logic               w_halt;
    logic               w_timeout;
    logic               w_evt_hit;
    logic [1:0]         w_evt_code;
    logic [DATA_W-1:0]  w_evt_result;

    assign w_tohost  = bus.mem_we_i && (bus.mem_addr_i == TOHOST_ADDR);
    assign w_halt    = (bus.pc_i == HALT_PC);
    assign w_timeout = (MAX_CYCLES != 0) && (cycles_q == c_TIMEOUT_AT);

    // Run-ending events, highest priority first; only consumed in RUN.
    always_comb begin
        w_evt_hit    = 1'b1;
        w_evt_code   = c_PASS;
        w_evt_result = '0;
        if (w_tohost) begin
            w_evt_code   = (bus.mem_wdata_i == DATA_W'(1)) ? c_PASS : c_TEST_FAIL;
            w_evt_result = bus.mem_wdata_i;
        end else if (w_halt) begin
            w_evt_code   = c_PASS;
        end else if (bus.abort_i) begin
            w_evt_code   = c_ABORT;
        end else if (w_timeout) begin
            w_evt_code   = c_TIMEOUT;
        end else begin
            w_evt_hit    = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        core_rst_n_d = core_rst_n_q;
        core_en_d    = core_en_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_code_d  = fail_code_q;
        cycles_d     = cycles_q;
        result_d     = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    state_d      = ST_RESET;
                    hold_d       = c_HOLD_LOAD;
                    core_rst_n_d = 1'b0;
                    core_en_d    = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_code_d  = c_PASS;
                    cycles_d     = '0;
                    result_d     = '0;
                end
            end
            ST_RESET: begin
                if (hold_q == '0) begin
                    state_d      = ST_RUN;
                    core_rst_n_d = 1'b1;
                    core_en_d    = 1'b1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_RUN: begin
                cycles_d = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
                if (w_evt_hit) begin
                    state_d     = ST_DONE;
                    core_en_d   = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = (w_evt_code == c_PASS);
                    fail_code_d = w_evt_code;
                    result_d    = w_evt_result;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            core_rst_n_q <= 1'b0;
            core_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_code_q  <= c_PASS;
            cycles_q     <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_rst_n_q <= core_rst_n_d;
            core_en_q    <= core_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_code_q  <= fail_code_d;
            cycles_q     <= cycles_d;
            result_q     <= result_d;
        end
    end

    assign bus.core_rst_n_o = core_rst_n_q;
    assign bus.core_en_o    = core_en_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.pass_o       = pass_q;
    assign bus.fail_code_o  = fail_code_q;
    assign bus.cycles_o     = cycles_q;
    assign bus.result_o     = result_q;

endmodule
`default_nettype wire
